// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared types and frame geometry defaults for the pixel filter path
package ps_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } ps_state_e;

  localparam int unsigned PS_H_ACTIVE     = 640;
  localparam int unsigned PS_V_ACTIVE     = 480;
  localparam int unsigned PS_FLUSH_PIXELS = 641;

  // Counter width that stays legal for a count range of one.
  function automatic int unsigned ps_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_filter_sequencer_if.sv
// rtl/ps_filter_sequencer_if.sv - upstream and downstream pixel handshake of the sequencer
interface ps_filter_sequencer_if;
  logic [11:0] i_data;
  logic        i_valid;
  logic        o_req;
  logic [11:0] o_data;
  logic        o_valid;
  logic        i_req;

  modport slave  (input i_data, i_valid, i_req, output o_req, o_data, o_valid);
  modport master (output i_data, i_valid, i_req, input o_req, o_data, o_valid);
endinterface

// File: rtl/ps_pixel_counter.sv
// rtl/ps_pixel_counter.sv - col/row raster position counter with wrap and last-pixel flag
module ps_pixel_counter
  import ps_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = PS_H_ACTIVE,
  parameter  int unsigned V_ACTIVE = PS_V_ACTIVE,
  localparam int unsigned CW       = ps_width(H_ACTIVE),
  localparam int unsigned RW       = ps_width(V_ACTIVE)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);

  logic col_last;
  logic row_last;

  assign col_last = (o_col == CW'(H_ACTIVE - 1));
  assign row_last = (o_row == RW'(V_ACTIVE - 1));
  assign o_last   = col_last & row_last;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_col <= '0;
      o_row <= '0;
    end else if (i_clear) begin
      o_col <= '0;
      o_row <= '0;
    end else if (i_advance) begin
      if (col_last) begin
        o_col <= '0;
        o_row <= row_last ? '0 : o_row + RW'(1);
      end else begin
        o_col <= o_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps_filter_sequencer.sv
// rtl/ps_filter_sequencer.sv - frame sequencer in front of the gaussian stage
// Forwards pixels, latches filter enable only between frames and drains the kernel with zero pixels.
module ps_filter_sequencer
  import ps_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = PS_H_ACTIVE,
  parameter int unsigned V_ACTIVE     = PS_V_ACTIVE,
  parameter int unsigned FLUSH_PIXELS = PS_FLUSH_PIXELS
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_cfg_wr,
  input  logic                        i_cfg_enable,
  ps_filter_sequencer_if.slave        pix,
  output logic                        o_enable,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_overflow
);

  localparam int unsigned CW = ps_width(H_ACTIVE);
  localparam int unsigned RW = ps_width(V_ACTIVE);
  localparam int unsigned FW = ps_width(FLUSH_PIXELS + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_PIXELS - 1);

  ps_state_e      state;
  logic           pend_enable;
  logic [FW-1:0]  flush_cnt;
  logic           accept;
  logic           last_pixel;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           unused_pos;

  assign pix.o_req = ((state == IDLE) || (state == ACTIVE)) & pix.i_req;
  assign accept    = pix.i_valid & pix.o_req;

  // Raster position is exported by the counter for other stages; here only the last flag matters.
  assign unused_pos = ^{col, row};

  ps_pixel_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_counter (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (state == DONE),
    .i_advance (accept),
    .o_col     (col),
    .o_row     (row),
    .o_last    (last_pixel)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      pend_enable  <= 1'b0;
      flush_cnt    <= '0;
      pix.o_data   <= '0;
      pix.o_valid  <= 1'b0;
      o_enable     <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      pix.o_valid  <= 1'b0;
      o_frame_done <= 1'b0;

      if (i_cfg_wr) begin
        pend_enable <= i_cfg_enable;
      end

      // A drop in the same cycle as a config write must leave the flag set.
      if (pix.i_valid & ~pix.o_req) begin
        o_overflow <= 1'b1;
      end else if (i_cfg_wr) begin
        o_overflow <= 1'b0;
      end

      case (state)
        IDLE, ACTIVE: begin
          if (state == IDLE) begin
            flush_cnt <= '0;
          end
          if (accept) begin
            pix.o_data  <= pix.i_data;
            pix.o_valid <= 1'b1;
            if (last_pixel) begin
              state  <= o_enable ? FLUSH : DONE;
              o_busy <= o_enable;
            end else begin
              state  <= ACTIVE;
              o_busy <= 1'b1;
            end
          end else if (state == IDLE) begin
            o_enable <= pend_enable;
          end
        end
        FLUSH: begin
          if (pix.i_req) begin
            pix.o_data  <= '0;
            pix.o_valid <= 1'b1;
            flush_cnt   <= flush_cnt + FW'(1);
            if (flush_cnt == FLUSH_LAST) begin
              state  <= DONE;
              o_busy <= 1'b0;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_filter_sequencer.sv
// tb/tb_ps_filter_sequencer.sv - scoreboard bench for ps_filter_sequencer on a 4x3 frame
module tb_ps_filter_sequencer;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int F    = 5;
  localparam int NPIX = H * V;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic cfg_wr = 1'b0;
  logic cfg_en = 1'b0;
  logic o_enable, o_busy, o_frame_done, o_overflow;

  ps_filter_sequencer_if pif ();

  ps_filter_sequencer #(
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .FLUSH_PIXELS (F)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_cfg_wr     (cfg_wr),
    .i_cfg_enable (cfg_en),
    .pix          (pif.slave),
    .o_enable     (o_enable),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int          checks      = 0;
  int          failures    = 0;
  int          cycle       = 0;
  int          last_valid  = -10;
  int          frames_done = 0;
  int          bp_mode     = 0;
  logic        frame_en    = 1'b0;
  logic        model_pend  = 1'b0;
  logic        model_ovf   = 1'b0;
  logic        prev_req    = 1'b1;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every presented pixel is popped against the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (pif.o_valid === 1'b1) begin
        chk("valid_follows_req", {31'd0, prev_req}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel actual=%0h required=none", pif.o_data);
        end else begin
          chk("pixel_data", {20'd0, pif.o_data}, {20'd0, exp_q.pop_front()});
        end
        chk("enable_during_frame", {31'd0, o_enable}, {31'd0, frame_en});
        last_valid = cycle;
      end
      if (o_frame_done === 1'b1) begin
        frames_done++;
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_after_last_pixel", cycle - last_valid, 1);
        chk("enable_at_done", {31'd0, o_enable}, {31'd0, frame_en});
        chk("busy_at_done", {31'd0, o_busy}, 0);
      end
      prev_req = pif.i_req;
    end
  end

  initial begin
    pif.i_req = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       pif.i_req = 1'($urandom_range(0, 1));
        2:       pif.i_req = ~pif.i_req;
        default: pif.i_req = 1'b1;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic v);
    cfg_wr = 1'b1;
    cfg_en = v;
    tick(1);
    cfg_wr     = 1'b0;
    model_pend = v;
    model_ovf  = 1'b0;
  endtask

  // Offers a pixel only on a cycle the sequencer will take it, so no drop is provoked.
  task automatic send_pixel(input logic [11:0] d, input bit do_cfg, input logic cfg_v);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (pif.o_req === 1'b1) begin
        pif.i_valid = 1'b1;
        pif.i_data  = d;
        exp_q.push_back(d);
        if (do_cfg) begin
          cfg_wr = 1'b1;
          cfg_en = cfg_v;
        end
        @(posedge clk);
        #1;
        pif.i_valid = 1'b0;
        cfg_wr      = 1'b0;
        if (do_cfg) begin
          model_pend = cfg_v;
          model_ovf  = 1'b0;
        end
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout actual=%0d required=<=200", n);
          done = 1;
        end
      end
    end
  endtask

  task automatic run_frame(input bit seq_data, input int cfg_at, input logic cfg_v,
                           input int gap_max, input bit flush_drop);
    int          fd0;
    int          n;
    logic [11:0] d;
    fd0      = frames_done;
    frame_en = model_pend;
    for (int i = 0; i < NPIX; i++) begin
      d = seq_data ? 12'(i + 1) : 12'($urandom);
      send_pixel(d, cfg_at == i, cfg_v);
      if (i == 0) chk("busy_in_frame", {31'd0, o_busy}, 1);
      if (i < NPIX - 1 && gap_max > 0) tick($urandom_range(0, gap_max));
    end
    if (frame_en) repeat (F) exp_q.push_back(12'd0);
    if (flush_drop) begin
      pif.i_valid = 1'b1;
      pif.i_data  = 12'hABC;
      tick(3);
      pif.i_valid = 1'b0;
      model_ovf   = 1'b1;
    end
    n = 0;
    while (frames_done == fd0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("one_done_pulse", frames_done - fd0, 1);
    tick(2);
    chk("enable_after_frame", {31'd0, o_enable}, {31'd0, model_pend});
    chk("overflow_after_frame", {31'd0, o_overflow}, {31'd0, model_ovf});
    chk("busy_after_frame", {31'd0, o_busy}, 0);
  endtask

  initial begin
    pif.i_valid = 1'b0;
    pif.i_data  = '0;
    #23;
    chk("reset_valid", {31'd0, pif.o_valid}, 0);
    chk("reset_data", {20'd0, pif.o_data}, 0);
    chk("reset_enable", {31'd0, o_enable}, 0);
    chk("reset_busy", {31'd0, o_busy}, 0);
    chk("reset_overflow", {31'd0, o_overflow}, 0);
    chk("reset_req_idle", {31'd0, pif.o_req}, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    // Filtered frame with sequential data.
    cfg_write(1'b1);
    tick(2);
    chk("enable_before_frame", {31'd0, o_enable}, 1);
    run_frame(1, -1, 1'b0, 0, 0);

    // Unfiltered frame.
    cfg_write(1'b0);
    tick(2);
    run_frame(0, -1, 1'b0, 0, 0);

    // Mid-frame disable takes effect only after the flush.
    cfg_write(1'b1);
    tick(2);
    run_frame(0, 5, 1'b0, 1, 0);

    // Pixels offered during flush are dropped and flagged; a write clears the flag.
    cfg_write(1'b1);
    tick(2);
    run_frame(0, -1, 1'b0, 0, 1);
    cfg_write(1'b1);
    tick(1);
    chk("overflow_cleared", {31'd0, o_overflow}, 0);
    tick(1);

    // Alternating downstream request spreads both pixels and flush.
    bp_mode = 2;
    tick(2);
    run_frame(0, -1, 1'b0, 0, 0);
    bp_mode = 0;
    tick(2);

    // Config write together with the first pixel stays pending for the next frame.
    run_frame(0, 0, 1'b0, 0, 0);

    // Random enable, data, gaps and backpressure.
    bp_mode = 1;
    for (int k = 0; k < 3; k++) begin
      cfg_write(1'($urandom_range(0, 1)));
      tick(2);
      run_frame(0, -1, 1'b0, 2, 0);
    end
    bp_mode = 0;
    tick(3);

    // Reset in the middle of a frame aborts without flush.
    cfg_write(1'b1);
    tick(2);
    frame_en = 1'b1;
    for (int i = 0; i < 7; i++) send_pixel(12'($urandom), 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, pif.o_valid}, 0);
    chk("abort_data", {20'd0, pif.o_data}, 0);
    chk("abort_enable", {31'd0, o_enable}, 0);
    chk("abort_busy", {31'd0, o_busy}, 0);
    chk("abort_overflow", {31'd0, o_overflow}, 0);
    chk("abort_done", {31'd0, o_frame_done}, 0);
    exp_q.delete();
    model_pend = 1'b0;
    model_ovf  = 1'b0;
    frame_en   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_frame(0, -1, 1'b0, 0, 0);

    tick(5);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
